// File: rtl/iq_fir_tdm_scheduler_pkg.sv
// Shared definitions for the I/Q time-division FIR scheduler: channel tags,
// issue-FSM encoding and default sample width.
package iq_fir_tdm_scheduler_pkg;

  localparam int   WIDTH_DEF = 16;

  localparam logic CH_I = 1'b0;
  localparam logic CH_Q = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND_I = 2'd1,
    ST_SEND_Q = 2'd2
  } tdm_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; rd_data shows the head whenever
// empty is low. A write while full is accepted only if a read happens too.
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iq_fir_tdm_scheduler.sv
// Shares one 2-channel smoothing FIR between I and Q: buffers both branches,
// issues aligned I-then-Q pairs and rebuilds the I_up2/Q_up2 pair on output.
module iq_fir_tdm_scheduler
  import iq_fir_tdm_scheduler_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_32M768,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] I_tdata,
  input  logic             I_tvalid,
  input  logic [WIDTH-1:0] Q_tdata,
  input  logic             Q_tvalid,
  output logic [WIDTH-1:0] flt_s_tdata,
  output logic             flt_s_tvalid,
  output logic             flt_s_tlast,
  input  logic             flt_s_tready,
  input  logic [WIDTH-1:0] flt_m_tdata,
  input  logic             flt_m_tvalid,
  input  logic             flt_m_tlast,
  output logic [WIDTH-1:0] I_up2,
  output logic [WIDTH-1:0] Q_up2,
  output logic             vld,
  output logic             in_overflow,
  output logic             sync_err
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  tdm_state_e       state;
  logic [WIDTH-1:0] i_head, q_head, i_hold;
  logic             i_full, i_empty, q_full, q_empty;
  logic [CW-1:0]    i_cnt, q_cnt;
  logic             pop, i_wr, q_wr, i_more, q_more;
  logic             out_phase;

  // Both FIFOs pop together on the Q handshake, keeping I_k paired with Q_k.
  assign pop  = (state == ST_SEND_Q) & flt_s_tready;
  assign i_wr = I_tvalid & (~i_full | pop);
  assign q_wr = Q_tvalid & (~q_full | pop);

  assign i_more = (i_cnt > CW'(1)) | i_wr;
  assign q_more = (q_cnt > CW'(1)) | q_wr;

  sync_fifo_fwft #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_i_fifo (
    .clk     (clk_32M768),
    .rst_n   (rst_n),
    .wr_en   (i_wr),
    .wr_data (I_tdata),
    .rd_en   (pop),
    .rd_data (i_head),
    .full    (i_full),
    .empty   (i_empty),
    .count   (i_cnt)
  );

  sync_fifo_fwft #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_q_fifo (
    .clk     (clk_32M768),
    .rst_n   (rst_n),
    .wr_en   (q_wr),
    .wr_data (Q_tdata),
    .rd_en   (pop),
    .rd_data (q_head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_cnt)
  );

  // Heads only move on pop, so tdata stays stable while tready is low.
  assign flt_s_tdata = !flt_s_tvalid ? '0 : (flt_s_tlast ? q_head : i_head);

  always_ff @(posedge clk_32M768 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      flt_s_tvalid <= 1'b0;
      flt_s_tlast  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!i_empty && !q_empty) begin
            state        <= ST_SEND_I;
            flt_s_tvalid <= 1'b1;
            flt_s_tlast  <= 1'b0;
          end
        end
        ST_SEND_I: begin
          if (flt_s_tready) begin
            state       <= ST_SEND_Q;
            flt_s_tlast <= 1'b1;
          end
        end
        ST_SEND_Q: begin
          if (flt_s_tready) begin
            flt_s_tlast <= 1'b0;
            if (i_more && q_more) begin
              state <= ST_SEND_I;
            end else begin
              state        <= ST_IDLE;
              flt_s_tvalid <= 1'b0;
            end
          end
        end
        default: begin
          state        <= ST_IDLE;
          flt_s_tvalid <= 1'b0;
          flt_s_tlast  <= 1'b0;
        end
      endcase
    end
  end

  // tlast is trusted over out_phase so a filter that was not reset with us
  // realigns on its first Q beat.
  always_ff @(posedge clk_32M768 or negedge rst_n) begin
    if (!rst_n) begin
      out_phase   <= CH_I;
      i_hold      <= '0;
      I_up2       <= '0;
      Q_up2       <= '0;
      vld         <= 1'b0;
      sync_err    <= 1'b0;
      in_overflow <= 1'b0;
    end else begin
      vld <= 1'b0;
      if ((I_tvalid && !i_wr) || (Q_tvalid && !q_wr)) in_overflow <= 1'b1;
      if (flt_m_tvalid) begin
        if (flt_m_tlast != out_phase) sync_err <= 1'b1;
        if (flt_m_tlast) begin
          if (out_phase == CH_Q) begin
            I_up2 <= i_hold;
            Q_up2 <= flt_m_tdata;
            vld   <= 1'b1;
          end
          out_phase <= CH_I;
        end else begin
          i_hold    <= flt_m_tdata;
          out_phase <= CH_Q;
        end
      end
    end
  end

endmodule

// File: tb/tb_iq_fir_tdm_scheduler.sv
// Randomised scoreboard bench for iq_fir_tdm_scheduler with a 3-cycle
// delay-line filter model and a queue-based reference of the pairing rules.
module tb_iq_fir_tdm_scheduler;

  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] I_tdata = '0, Q_tdata = '0;
  logic         I_tvalid = 1'b0, Q_tvalid = 1'b0;
  logic         flt_s_tready = 1'b1;
  logic [W-1:0] flt_s_tdata, flt_m_tdata, I_up2, Q_up2;
  logic         flt_s_tvalid, flt_s_tlast, flt_m_tvalid, flt_m_tlast;
  logic         vld, in_overflow, sync_err;

  always #5 clk = ~clk;

  iq_fir_tdm_scheduler #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk_32M768   (clk),
    .rst_n        (rst_n),
    .I_tdata      (I_tdata),
    .I_tvalid     (I_tvalid),
    .Q_tdata      (Q_tdata),
    .Q_tvalid     (Q_tvalid),
    .flt_s_tdata  (flt_s_tdata),
    .flt_s_tvalid (flt_s_tvalid),
    .flt_s_tlast  (flt_s_tlast),
    .flt_s_tready (flt_s_tready),
    .flt_m_tdata  (flt_m_tdata),
    .flt_m_tvalid (flt_m_tvalid),
    .flt_m_tlast  (flt_m_tlast),
    .I_up2        (I_up2),
    .Q_up2        (Q_up2),
    .vld          (vld),
    .in_overflow  (in_overflow),
    .sync_err     (sync_err)
  );

  // Filter model: fixed 3-cycle delay, plus a one-shot injected beat.
  logic [2:0]   pv = '0, pl = '0;
  logic [W-1:0] pd [3];
  logic         inj_v = 1'b0, inj_l = 1'b0;
  logic [W-1:0] inj_d = '0;
  assign flt_m_tvalid = pv[2] | inj_v;
  assign flt_m_tlast  = inj_v ? inj_l : pl[2];
  assign flt_m_tdata  = inj_v ? inj_d : pd[2];

  typedef struct { logic [W-1:0] i; logic [W-1:0] q; } pair_t;
  logic [W-1:0] im[$], qm[$];
  pair_t        pairs[$];
  int           n_chk = 0, n_fail = 0;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic fail_now(input string n);
    n_chk++;
    n_fail++;
    $display("FAIL %s", n);
  endtask

  // Reference model: per-channel queues bounded at D, pairs formed on the Q issue.
  initial begin
    logic         exp_q, exp_ovf, hold_prev, hs, prev_l;
    logic [W-1:0] prev_d;
    exp_q = 0; exp_ovf = 0; hold_prev = 0; prev_l = 0; prev_d = '0;
    pd[0] = '0; pd[1] = '0; pd[2] = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        im.delete(); qm.delete(); pairs.delete();
        exp_q = 0; exp_ovf = 0; hold_prev = 0;
        pv <= '0;
      end else begin
        check("in_overflow", in_overflow, exp_ovf);
        if (hold_prev) begin
          check("hold_tvalid", flt_s_tvalid, 1);
          check("hold_tdata", flt_s_tdata, prev_d);
          check("hold_tlast", flt_s_tlast, prev_l);
        end
        hs = flt_s_tvalid && flt_s_tready;
        if (hs) begin
          if (!exp_q) begin
            if (im.size() == 0) fail_now("issue_i_without_sample");
            else begin
              check("issue_i_data", flt_s_tdata, im[0]);
              check("issue_i_tlast", flt_s_tlast, 0);
            end
            exp_q = 1;
          end else begin
            if (im.size() == 0 || qm.size() == 0) fail_now("issue_q_without_pair");
            else begin
              check("issue_q_data", flt_s_tdata, qm[0]);
              check("issue_q_tlast", flt_s_tlast, 1);
              pairs.push_back('{i: im[0], q: qm[0]});
              void'(im.pop_front());
              void'(qm.pop_front());
            end
            exp_q = 0;
          end
        end
        hold_prev = flt_s_tvalid && !flt_s_tready;
        prev_d = flt_s_tdata;
        prev_l = flt_s_tlast;
        if (I_tvalid) begin
          if (im.size() < D) im.push_back(I_tdata); else exp_ovf = 1;
        end
        if (Q_tvalid) begin
          if (qm.size() < D) qm.push_back(Q_tdata); else exp_ovf = 1;
        end
        pv    <= {pv[1:0], hs};
        pl    <= {pl[1:0], flt_s_tlast};
        pd[0] <= flt_s_tdata;
        pd[1] <= pd[0];
        pd[2] <= pd[1];
      end
    end
  end

  // Output monitor
  initial begin
    pair_t p;
    forever begin
      @(posedge clk);
      if (rst_n && vld) begin
        if (pairs.size() == 0) fail_now("unexpected_vld");
        else begin
          p = pairs.pop_front();
          check("I_up2", I_up2, p.i);
          check("Q_up2", Q_up2, p.q);
        end
      end
    end
  end

  task automatic drive(input logic iv, input logic qv, input logic [W-1:0] id, input logic [W-1:0] qd);
    I_tvalid = iv; Q_tvalid = qv; I_tdata = id; Q_tdata = qd;
    @(negedge clk);
    I_tvalid = 0; Q_tvalid = 0;
  endtask

  task automatic wait_drain(input string n);
    int k;
    k = 0;
    while ((im.size() != 0 || qm.size() != 0 || pairs.size() != 0 || pv != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({n, "_drained"}, (k < 200) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_q_issue(output logic ok);
    int k;
    k = 0;
    while (!(flt_s_tvalid && flt_s_tlast) && k < 50) begin
      @(negedge clk);
      k++;
    end
    ok = (k < 50);
    if (!ok) fail_now("timeout_waiting_q_issue");
  endtask

  task automatic check_reset_outputs(input string n);
    check({n, "_tvalid"}, flt_s_tvalid, 0);
    check({n, "_tlast"}, flt_s_tlast, 0);
    check({n, "_vld"}, vld, 0);
    check({n, "_I_up2"}, I_up2, 0);
    check({n, "_Q_up2"}, Q_up2, 0);
    check({n, "_overflow"}, in_overflow, 0);
    check({n, "_sync_err"}, sync_err, 0);
  endtask

  initial begin
    logic ok;
    logic [W-1:0] a, b;
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  initial begin
    logic ok;
    logic [W-1:0] a, b;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1;
    @(negedge clk);

    // Fixed pairs every two cycles
    for (int k = 0; k < 6; k++) begin
      drive(1, 1, 16'h1234, 16'hABCD);
      drive(0, 0, 0, 0);
    end
    wait_drain("basic");
    check("basic_overflow", in_overflow, 0);

    // Backpressure held across the Q beat
    a = W'($urandom); b = W'($urandom);
    drive(1, 1, a, b);
    wait_q_issue(ok);
    flt_s_tready = 0;
    repeat (5) begin
      @(negedge clk);
      check("stall_q_data", flt_s_tdata, b);
      check("stall_q_tlast", flt_s_tlast, 1);
    end
    flt_s_tready = 1;
    wait_drain("stall");

    // Continuous input overruns the FIFOs
    for (int k = 0; k < 20; k++) drive(1, 1, W'($urandom), W'($urandom));
    check("burst_overflow", in_overflow, 1);
    wait_drain("burst");

    // I arrives three cycles ahead of Q
    a = W'($urandom); b = W'($urandom);
    drive(1, 0, a, 0);
    repeat (3) begin
      check("wait_for_q_no_issue", flt_s_tvalid, 0);
      @(negedge clk);
    end
    drive(0, 1, 0, b);
    wait_drain("skew");

    // Stray Q beat from an out-of-step filter
    check("sync_err_before", sync_err, 0);
    inj_v = 1; inj_l = 1; inj_d = W'($urandom);
    @(negedge clk);
    inj_v = 0;
    @(negedge clk);
    check("sync_err_after", sync_err, 1);
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, W'($urandom), W'($urandom));
      drive(0, 0, 0, 0);
    end
    wait_drain("resync");

    // Reset while stalled in the Q issue
    drive(1, 1, W'($urandom), W'($urandom));
    wait_q_issue(ok);
    flt_s_tready = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1;
    flt_s_tready = 1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_fifo_empty", flt_s_tvalid, 0);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 16'h1234, 16'hABCD);
      drive(0, 0, 0, 0);
    end
    wait_drain("post_reset");
    check("post_reset_overflow", in_overflow, 0);

    // Random traffic and backpressure
    for (int k = 0; k < 300; k++) begin
      flt_s_tready = ($urandom % 4) != 0;
      drive(($urandom % 3) != 0, ($urandom % 3) != 0, W'($urandom), W'($urandom));
    end
    flt_s_tready = 1;
    I_tvalid = 0; Q_tvalid = 0;
    // Unequal random counts can leave one channel's queue permanently non-empty.
    repeat (40) @(negedge clk);
    check("rand_pairs_outstanding", pairs.size(), 0);
    check("rand_unpaired_left", ((im.size() == 0) || (qm.size() == 0)) ? 1 : 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
